ft_recovery_unit: RTL

FT_RECOVERY_UNIT -- requirements
Module: ft_recovery_unit

---
 rtl/ft_recovery_unit.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/ft_recovery_unit.sv
// ft_recovery_unit
// Lock-step fault-tolerance recovery unit for a pair of redundant cores.
// Every cycle the writebacks of core A and core B are compared. Matching
// writebacks are mirrored into a shadow register file, and committed PCs are
// checkpointed. A mismatch halts both cores. The unit then replays the whole
// shadow file into them and restarts them at the checkpointed PC. Too many
// back-to-back recoveries without a clean write end in a sticky FATAL state.
//
// Ports
//   clk_i                 rising-edge clock
//   rst_n                 asynchronous active-low reset
//   we_a_i / we_b_i       per-port write enables, core A / core B
//   addr_a_i / addr_b_i   packed per-port write addresses
//   data_a_i / data_b_i   packed per-port write data
//   pc_valid_i, pc_i      committed PC from core A
//   halt_o                hold fetch of both cores
//   replay_we_o           restore-write strobe to both cores
//   replay_addr_o         restore address, zero when not replaying
//   replay_data_o         restore data, zero when not replaying
//   resume_o              one-cycle restart pulse, cores restart at pc_o
//   pc_o                  last checkpointed PC
//   fatal_o               sticky unrecoverable-fault flag
//   err_count_o           saturating count of detected errors
//                         (only present when FT_ERR_COUNT_EN is defined)
//
// Optional feature macro: FT_ERR_COUNT_EN
module ft_recovery_unit #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 2,
    parameter int MAX_RETRY  = 3
) (
    input  logic                             clk_i,
    input  logic                             rst_n,
    input  logic [NUM_PORTS-1:0]             we_a_i,
    input  logic [NUM_PORTS-1:0]             we_b_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr_a_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr_b_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  data_a_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  data_b_i,
    input  logic                             pc_valid_i,
    input  logic [DATA_WIDTH-1:0]            pc_i,
    output logic                             halt_o,
    output logic                             replay_we_o,
    output logic [ADDR_WIDTH-1:0]            replay_addr_o,
    output logic [DATA_WIDTH-1:0]            replay_data_o,
    output logic                             resume_o,
    output logic [DATA_WIDTH-1:0]            pc_o,
`ifdef FT_ERR_COUNT_EN
    output logic [15:0]                      err_count_o,
`endif
    output logic                             fatal_o
);

    localparam int                    DEPTH     = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [3:0]            RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        REPLAY,
        RESUME,
        FATAL
    } state_t;

    state_t                  state_q;
    logic [3:0]              retryCount_q;
    logic [ADDR_WIDTH-1:0]   replayCount_q;
    logic [ADDR_WIDTH-1:0]   replayCount_d;
    logic [DATA_WIDTH-1:0]   pcCheckpoint_q;
    logic [DATA_WIDTH-1:0]   shadow_q [DEPTH];
    logic                    halt_q;
    logic                    replayWe_q;
    logic [ADDR_WIDTH-1:0]   replayAddr_q;
    logic [DATA_WIDTH-1:0]   replayData_q;
    logic                    resume_q;
    logic                    fatal_q;
    logic                    coreMismatch;
    logic                    cleanCommit;

    // A port disagrees if only one core writes, or both write but the
    // address or data differ. Ports where neither core writes never disagree.
    always_comb begin
        coreMismatch = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (we_a_i[p] != we_b_i[p]) begin
                coreMismatch = 1'b1;
            end else if (we_a_i[p] &&
                         ((addr_a_i[p*ADDR_WIDTH +: ADDR_WIDTH] != addr_b_i[p*ADDR_WIDTH +: ADDR_WIDTH]) ||
                          (data_a_i[p*DATA_WIDTH +: DATA_WIDTH] != data_b_i[p*DATA_WIDTH +: DATA_WIDTH]))) begin
                coreMismatch = 1'b1;
            end
        end
    end

    // Core inputs matter only in IDLE. Outside IDLE they are neither compared nor stored.
    assign cleanCommit   = (state_q == IDLE) && !coreMismatch;
    assign replayCount_d = replayCount_q + 1'b1;

    // Ports are walked in ascending order. On an address clash the last
    // non-blocking write wins, so the highest port index takes priority.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (cleanCommit) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (we_a_i[p]) begin
                    shadow_q[addr_a_i[p*ADDR_WIDTH +: ADDR_WIDTH]] <= data_a_i[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Recovery FSM. The outputs are registered together with the state.
    // Each transition therefore loads the output values of the state being entered.
    // The replay outputs are preloaded one step ahead, so the address and data
    // on the outputs always match the current replay counter.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            retryCount_q   <= '0;
            replayCount_q  <= '0;
            pcCheckpoint_q <= '0;
            halt_q         <= 1'b0;
            replayWe_q     <= 1'b0;
            replayAddr_q   <= '0;
            replayData_q   <= '0;
            resume_q       <= 1'b0;
            fatal_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (coreMismatch) begin
                        halt_q <= 1'b1;
                        if (retryCount_q == RETRY_MAX) begin
                            state_q <= FATAL;
                            fatal_q <= 1'b1;
                        end else begin
                            state_q      <= HALT;
                            retryCount_q <= retryCount_q + 4'd1;
                        end
                    end else begin
                        if (pc_valid_i) begin
                            pcCheckpoint_q <= pc_i;
                        end
                        // A clean write proves that the cores have made forward progress.
                        if (|we_a_i) begin
                            retryCount_q <= '0;
                        end
                    end
                end
                HALT: begin
                    state_q       <= REPLAY;
                    replayCount_q <= '0;
                    replayWe_q    <= 1'b1;
                    replayAddr_q  <= '0;
                    replayData_q  <= shadow_q[0];
                end
                REPLAY: begin
                    if (replayCount_q == LAST_ADDR) begin
                        state_q       <= RESUME;
                        replayCount_q <= '0;
                        halt_q        <= 1'b0;
                        replayWe_q    <= 1'b0;
                        replayAddr_q  <= '0;
                        replayData_q  <= '0;
                        resume_q      <= 1'b1;
                    end else begin
                        replayCount_q <= replayCount_d;
                        replayAddr_q  <= replayCount_d;
                        replayData_q  <= shadow_q[replayCount_d];
                    end
                end
                RESUME: begin
                    state_q  <= IDLE;
                    resume_q <= 1'b0;
                end
                FATAL: begin
                    state_q <= FATAL;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign halt_o        = halt_q;
    assign replay_we_o   = replayWe_q;
    assign replay_addr_o = replayAddr_q;
    assign replay_data_o = replayData_q;
    assign resume_o      = resume_q;
    assign pc_o          = pcCheckpoint_q;
    assign fatal_o       = fatal_q;

`ifdef FT_ERR_COUNT_EN
    logic [15:0] errCount_q;

    // Counts every mismatch that is seen in IDLE, including the one that leads
    // into FATAL. The counter holds at its maximum instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            errCount_q <= '0;
        end else if ((state_q == IDLE) && coreMismatch && (errCount_q != 16'hFFFF)) begin
            errCount_q <= errCount_q + 16'd1;
        end
    end

    assign err_count_o = errCount_q;
`endif

endmodule
